// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// Each accepted state is XORed with the current round key, then the schedule advances.
module add_round_key_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   out_round
);

  typedef enum logic {
    NO_KEY = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte 0x00 sits in the top byte of the table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  state_t       state_q;
  logic [127:0] ck_q;
  logic [127:0] rk_q;
  logic [127:0] rk_d;
  logic [3:0]   rnd_q;
  logic [3:0]   rnd_d;
  logic         out_valid_q;
  logic [127:0] out_data_q;
  logic [3:0]   out_round_q;

  logic         accept;
  logic [7:0]   rcon;
  logic [31:0]  w3_rot;
  logic [31:0]  w3_sub;
  logic [31:0]  t;
  logic [31:0]  w0n;
  logic [31:0]  w1n;
  logic [31:0]  w2n;
  logic [31:0]  w3n;

  assign in_ready = (state_q == RUN) & ~key_load
                  & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_round = out_round_q;

  assign w3_rot = {rk_q[23:0], rk_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign w3_sub[8*i +: 8] = sbox(w3_rot[8*i +: 8]);
  end

  // rcon for the round being generated, i.e. rnd_q + 1.
  always_comb begin
    rcon = 8'h00;
    case (rnd_q)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t   = w3_sub ^ {rcon, 24'h0};
  assign w0n = rk_q[127:96] ^ t;
  assign w1n = rk_q[95:64]  ^ w0n;
  assign w2n = rk_q[63:32]  ^ w1n;
  assign w3n = rk_q[31:0]   ^ w2n;

  always_comb begin
    rk_d  = {w0n, w1n, w2n, w3n};
    rnd_d = rnd_q + 4'd1;
    if (rnd_q == 4'd10) begin
      rk_d  = ck_q;
      rnd_d = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= NO_KEY;
      ck_q        <= '0;
      rk_q        <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_round_q <= '0;
    end else begin
      if (out_valid_q && out_ready && !accept) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= in_data ^ rk_q;
        out_round_q <= rnd_q;
      end
      if (key_load) begin
        state_q <= RUN;
        ck_q    <= key_in;
        rk_q    <= key_in;
        rnd_q   <= 4'd0;
      end else if (accept) begin
        rk_q  <= rk_d;
        rnd_q <= rnd_d;
      end
    end
  end

endmodule
